mult_norm_seq: RTL and testbench

Sequential front end of the single-precision multiplier. It unpacks two IEEE-754 binary32 operands and forms the 48-bit mantissa product with a radix-2 shift-add loop. It then normalizes the product and emits the 25-bit mantissa, guard, sticky, sign, exponent and rounding mode that the rounding stage consumes. Operands enter through a valid/ready handshake, and the result leaves through a second valid/ready handshake.

---
 rtl/round_defs_pkg.sv | 22 ++
 rtl/fp_classify.sv | 20 ++
 rtl/mult_norm_seq.sv | 169 ++++++++++++++++
 tb/tb_mult_norm_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/round_defs_pkg.sv
// Shared definitions for the multiplier front end: rounding-mode codes,
// controller states and binary32 exponent constants.
package round_defs;

    localparam logic [2:0] IEEE_NEAR = 3'd0;
    localparam logic [2:0] IEEE_ZERO = 3'd1;
    localparam logic [2:0] IEEE_PINF = 3'd2;
    localparam logic [2:0] IEEE_NINF = 3'd3;
    localparam logic [2:0] NEAR_UP   = 3'd4;
    localparam logic [2:0] AWAY_ZERO = 3'd5;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/fp_classify.sv
// Classifies one binary32 operand; denormals are reported as zero.
module fp_classify (
    input  logic [31:0] op_i,
    output logic        is_zero_o,
    output logic        is_inf_o,
    output logic        is_nan_o,
    output logic        hidden_o
);

    logic [7:0]  exp_w;
    logic [22:0] frac_w;

    assign exp_w     = op_i[30:23];
    assign frac_w    = op_i[22:0];
    assign hidden_o  = (exp_w != 8'd0);
    assign is_zero_o = (exp_w == 8'd0);
    assign is_inf_o  = (exp_w == 8'hFF) && (frac_w == 23'd0);
    assign is_nan_o  = (exp_w == 8'hFF) && (frac_w != 23'd0);

endmodule

// File: rtl/mult_norm_seq.sv
// Sequential binary32 multiplier front end: shift-add mantissa product,
// one-step normalization, and guard/sticky extraction for the rounder.
module mult_norm_seq
    import round_defs::*;
#(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             a,
    input  logic [31:0]             b,
    input  logic [2:0]              round_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    z_sign,
    output logic signed [EXP_W-1:0] z_exp,
    output logic [MANT_W:0]         mant_out,
    output logic                    guard,
    output logic                    sticky,
    output logic [2:0]              round_out,
    output logic                    is_zero,
    output logic                    is_inf,
    output logic                    is_nan
);

    localparam int CNT_W = $clog2(MANT_W);
    localparam int P_W   = 2 * MANT_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MANT_W - 1);

    state_t              state_q;
    logic [7:0]          ea_q, eb_q;
    logic [MANT_W-1:0]   ma_q, mb_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [P_W-1:0]      p_q, p_d;
    logic                out_valid_q, sign_q, guard_q, sticky_q;
    logic                zero_q, inf_q, nan_q;
    logic [EXP_W-1:0]    z_exp_q, exp_d;
    logic [MANT_W-1:0]   mant_q;
    logic [2:0]          round_q;

    logic [31:0] ops_w [2];
    logic [1:0]  op_zero_w, op_inf_w, op_nan_w, op_hid_w;
    logic        nan_w, inf_w, zero_w;

    assign ops_w[0] = a;
    assign ops_w[1] = b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cls
            fp_classify u_cls (
                .op_i      (ops_w[gi]),
                .is_zero_o (op_zero_w[gi]),
                .is_inf_o  (op_inf_w[gi]),
                .is_nan_o  (op_nan_w[gi]),
                .hidden_o  (op_hid_w[gi])
            );
        end
    endgenerate

    // inf x zero has no meaningful magnitude and is folded into NaN.
    assign nan_w  = (|op_nan_w) || (op_inf_w[0] && op_zero_w[1]) || (op_zero_w[0] && op_inf_w[1]);
    assign inf_w  = !nan_w && (|op_inf_w);
    assign zero_w = !nan_w && !inf_w && (|op_zero_w);

    always_comb begin
        p_d = p_q;
        if (mb_q[cnt_q]) begin
            p_d = p_q + ({{MANT_W{1'b0}}, ma_q} << cnt_q);
        end
        exp_d = {{(EXP_W-8){1'b0}}, ea_q} + {{(EXP_W-8){1'b0}}, eb_q}
              - (p_q[P_W-1] ? EXP_W'(BIAS - 1) : EXP_W'(BIAS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ea_q        <= '0;
            eb_q        <= '0;
            ma_q        <= '0;
            mb_q        <= '0;
            cnt_q       <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
            sign_q      <= 1'b0;
            z_exp_q     <= '0;
            mant_q      <= '0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            round_q     <= '0;
            zero_q      <= 1'b0;
            inf_q       <= 1'b0;
            nan_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        ea_q     <= a[30:23];
                        eb_q     <= b[30:23];
                        ma_q     <= {op_hid_w[0], a[22:0]};
                        mb_q     <= {op_hid_w[1], b[22:0]};
                        cnt_q    <= '0;
                        p_q      <= '0;
                        round_q  <= round_in;
                        sign_q   <= nan_w ? 1'b0 : (a[31] ^ b[31]);
                        nan_q    <= nan_w;
                        inf_q    <= inf_w;
                        zero_q   <= zero_w;
                        mant_q   <= '0;
                        guard_q  <= 1'b0;
                        sticky_q <= 1'b0;
                        if (nan_w || inf_w || zero_w) begin
                            z_exp_q     <= (nan_w || inf_w) ? EXP_W'(EXP_MAX) : '0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            z_exp_q <= '0;
                            state_q <= MUL;
                        end
                    end
                end
                MUL: begin
                    p_q   <= p_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    // Product of two [1,2) significands lies in [1,4): at most one shift.
                    if (p_q[P_W-1]) begin
                        mant_q   <= p_q[P_W-1 -: MANT_W];
                        guard_q  <= p_q[MANT_W-1];
                        sticky_q <= |p_q[MANT_W-2:0];
                    end else begin
                        mant_q   <= p_q[P_W-2 -: MANT_W];
                        guard_q  <= p_q[MANT_W-2];
                        sticky_q <= |p_q[MANT_W-3:0];
                    end
                    z_exp_q     <= exp_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign z_sign    = sign_q;
    assign z_exp     = z_exp_q;
    assign mant_out  = {1'b0, mant_q};
    assign guard     = guard_q;
    assign sticky    = sticky_q;
    assign round_out = round_q;
    assign is_zero   = zero_q;
    assign is_inf    = inf_q;
    assign is_nan    = nan_q;

endmodule

// File: tb/tb_mult_norm_seq.sv
// Directed and random bench for mult_norm_seq with an expected-result queue.
module tb_mult_norm_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b;
    logic [2:0]  round_in, round_out;
    logic        z_sign, guard, sticky, is_zero, is_inf, is_nan;
    logic [9:0]  z_exp;
    logic [24:0] mant_out;
    logic [43:0] obs;

    int tests = 0;
    int fails = 0;
    logic [43:0] sb_q [$];

    always #5 clk = ~clk;

    mult_norm_seq #(.MANT_W(24), .EXP_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .round_in  (round_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z_sign    (z_sign),
        .z_exp     (z_exp),
        .mant_out  (mant_out),
        .guard     (guard),
        .sticky    (sticky),
        .round_out (round_out),
        .is_zero   (is_zero),
        .is_inf    (is_inf),
        .is_nan    (is_nan)
    );

    assign obs = {z_sign, z_exp, mant_out, guard, sticky, round_out, is_zero, is_inf, is_nan};

    // Layout: {sign, exp[9:0], mant[24:0], guard, sticky, round[2:0], zero, inf, nan}
    function automatic logic [43:0] pk(input logic s, input logic [9:0] e, input logic [23:0] m,
                                       input logic g, input logic st, input logic [2:0] rm,
                                       input logic [2:0] fl);
        return {s, e, 1'b0, m, g, st, rm, fl};
    endfunction

    function automatic logic [43:0] model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
        logic [7:0]  ex, ey;
        logic        zx, zy, ix, iy, nx, ny, nan, inf, s;
        logic [47:0] prod;
        logic [9:0]  e;
        ex = x[30:23];
        ey = y[30:23];
        zx = (ex == 8'd0);
        zy = (ey == 8'd0);
        ix = (ex == 8'hFF) && (x[22:0] == 23'd0);
        iy = (ey == 8'hFF) && (y[22:0] == 23'd0);
        nx = (ex == 8'hFF) && (x[22:0] != 23'd0);
        ny = (ey == 8'hFF) && (y[22:0] != 23'd0);
        nan = nx || ny || (ix && zy) || (zx && iy);
        inf = !nan && (ix || iy);
        s = x[31] ^ y[31];
        if (nan) return pk(1'b0, 10'd255, 24'd0, 1'b0, 1'b0, rm, 3'b001);
        if (inf) return pk(s, 10'd255, 24'd0, 1'b0, 1'b0, rm, 3'b010);
        if (zx || zy) return pk(s, 10'd0, 24'd0, 1'b0, 1'b0, rm, 3'b100);
        prod = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
        if (prod[47]) begin
            e = 10'(int'(ex) + int'(ey) - 126);
            return pk(s, e, prod[47:24], prod[23], |prod[22:0], rm, 3'b000);
        end
        e = 10'(int'(ex) + int'(ey) - 127);
        return pk(s, e, prod[46:23], prod[22], |prod[21:0], rm, 3'b000);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [2:0] rm, input logic [43:0] want, input int lat_exp,
                          input int hold);
        int lat;
        logic [43:0] e;
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        round_in = rm;
        sb_q.push_back(want);
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~x;
        b        = $urandom;
        round_in = ~rm;
        chk({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
        lat = 1;
        while (!out_valid && lat < 100) begin
            in_valid = (lat >= 3 && lat < 6);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'(lat_exp));
        e = sb_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_data"}, 64'(obs), 64'(e));
            chk({tag, "_hold_ready"}, 64'({out_valid, in_ready}), 64'b10);
            @(negedge clk);
        end
        chk(tag, 64'(obs), 64'(e));
        $display("[TB] %s a=%h b=%h rm=%0d lat=%0d result=%h", tag, x, y, rm, lat, obs);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_after_handshake"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        int saw_valid;
        logic [31:0] rx, ry;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        round_in  = '0;
        repeat (2) @(negedge clk);
        chk("reset_ctrl", 64'({in_ready, out_valid}), 64'b10);
        chk("reset_data", 64'(obs), 64'd0);
        rst = 1'b0;

        run_op("one_x_one", 32'h3F800000, 32'h3F800000, 3'd0,
               pk(1'b0, 10'd127, 24'h800000, 1'b0, 1'b0, 3'd0, 3'b000), 26, 0);
        run_op("1p5_sq", 32'h3FC00000, 32'h3FC00000, 3'd1,
               pk(1'b0, 10'd128, 24'h900000, 1'b0, 1'b0, 3'd1, 3'b000), 26, 0);
        run_op("guard_set", 32'h3F800001, 32'h3FC00000, 3'd2,
               pk(1'b0, 10'd127, 24'hC00001, 1'b1, 1'b0, 3'd2, 3'b000), 26, 0);
        run_op("sticky_set", 32'h3F800001, 32'h3F800001, 3'd3,
               pk(1'b0, 10'd127, 24'h800002, 1'b0, 1'b1, 3'd3, 3'b000), 26, 10);
        run_op("inf_x_zero", 32'h7F800000, 32'h00000000, 3'd4,
               pk(1'b0, 10'd255, 24'd0, 1'b0, 1'b0, 3'd4, 3'b001), 1, 0);
        run_op("neg_inf", 32'hBF800000, 32'h7F800000, 3'd5,
               pk(1'b1, 10'd255, 24'd0, 1'b0, 1'b0, 3'd5, 3'b010), 1, 3);
        run_op("neg_zero", 32'h80000000, 32'h40000000, 3'd0,
               pk(1'b1, 10'd0, 24'd0, 1'b0, 1'b0, 3'd0, 3'b100), 1, 0);
        run_op("denorm_flush", 32'h00000001, 32'h3F800000, 3'd1,
               pk(1'b0, 10'd0, 24'd0, 1'b0, 1'b0, 3'd1, 3'b100), 1, 0);
        run_op("nan_sign", 32'hFFC00000, 32'h3F800000, 3'd2,
               pk(1'b0, 10'd255, 24'd0, 1'b0, 1'b0, 3'd2, 3'b001), 1, 0);
        run_op("small_exp", 32'h00800000, 32'h00800000, 3'd0,
               pk(1'b0, 10'h383, 24'h800000, 1'b0, 1'b0, 3'd0, 3'b000), 26, 0);

        // Abort in the middle of the multiply loop.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'h3FC00000;
        b        = 32'h3FC00000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ctrl", 64'({in_ready, out_valid}), 64'b10);
        chk("abort_data", 64'(obs), 64'd0);
        saw_valid = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1;
        end
        chk("abort_no_valid", 64'(saw_valid), 64'd0);
        $display("[TB] abort_mid_mul out_valid_seen=%0d", saw_valid);

        for (int i = 0; i < 8; i++) begin
            rx = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            ry = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            run_op($sformatf("rand%0d", i), rx, ry, 3'(i % 6), model(rx, ry, 3'(i % 6)), 26, i % 3);
        end

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
